// File: rtl/trig_pkg.sv
// Shared definitions for the trigger capture block: default widths and
// the acquisition state enumeration.
package trig_pkg;

  localparam int DW_DEFAULT = 14;
  localparam int AW_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    READ      = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Contents are never reset.
module capture_ram
  import trig_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          adc_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Write port: one sample per enabled cycle.
  always_ff @(posedge adc_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: data appears one cycle after the address is presented.
  always_ff @(posedge adc_clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trigger_capture.sv
// Pre/post trigger sample capture into a circular buffer, followed by an
// AXI-Stream readout of the record through a 2-entry skid buffer.
module trigger_capture
  import trig_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          adc_clk,
  input  logic          adc_rst,
  input  logic [DW-1:0] adc_dat_a,
  input  logic          trigger,
  input  logic          arm,
  input  logic [AW-1:0] pre_samples,
  input  logic [AW-1:0] post_samples,
  output logic          busy,
  output logic          triggered,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast
);

  // Lengths up to the full depth need one extra bit.
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH = {1'b1, {AW{1'b0}}};

  cap_state_t    state;
  logic [DW-1:0] dat_r;
  logic          trig_r;
  logic          trig_q;
  logic [AW-1:0] p_lat;
  logic [LW-1:0] n_lat;
  logic [AW-1:0] fill_cnt;
  logic [LW-1:0] post_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_issued;
  logic [LW-1:0] total_len;
  logic          inflight;
  logic          inflight_last;
  logic [1:0]    skid_cnt;
  logic [1:0]    skid_nxt;
  logic [DW-1:0] skid_dat1;
  logic          skid_last1;
  logic [DW-1:0] ram_q;

  logic          trig_edge;
  logic [LW-1:0] post_req;
  logic [LW-1:0] post_room;
  logic [LW-1:0] post_clamped;
  logic          wr_en;
  logic          pop;
  logic          rd_en;
  logic          issue_last;

  assign trig_edge    = trig_r & ~trig_q;
  assign post_req     = (post_samples == '0) ? LW'(1) : {1'b0, post_samples};
  assign post_room    = DEPTH - {1'b0, pre_samples};
  assign post_clamped = (post_req > post_room) ? post_room : post_req;
  assign wr_en        = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
  assign pop          = m_tvalid & m_tready;
  assign issue_last   = (rd_issued == (total_len - LW'(1)));
  // Only issue a read when the skid buffer is guaranteed room for its data.
  assign rd_en        = (state == READ) && (rd_issued != total_len) &&
                        (({1'b0, skid_cnt} + {2'b00, inflight}) <= ({2'b00, pop} + 3'd1));
  assign skid_nxt     = skid_cnt + {1'b0, inflight} - {1'b0, pop};

  capture_ram #(.DW(DW), .AW(AW)) u_ram (
    .adc_clk (adc_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (dat_r),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Register the ADC sample and comparator level once; the previous level feeds edge detection.
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      dat_r  <= '0;
      trig_r <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      dat_r  <= adc_dat_a;
      trig_r <= trigger;
      trig_q <= trig_r;
    end
  end

  // Acquisition sequencer: fill pre-trigger window, wait for an edge, fill post window, read out.
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      triggered     <= 1'b0;
      p_lat         <= '0;
      n_lat         <= '0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      wr_ptr        <= '0;
      rd_addr       <= '0;
      rd_issued     <= '0;
      total_len     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      triggered     <= 1'b0;
      inflight      <= rd_en;
      inflight_last <= issue_last;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_addr   <= rd_addr + AW'(1);
        rd_issued <= rd_issued + LW'(1);
      end
      case (state)
        IDLE: begin
          if (arm) begin
            p_lat    <= pre_samples;
            n_lat    <= post_clamped;
            fill_cnt <= '0;
            post_cnt <= '0;
            busy     <= 1'b1;
            state    <= PRE;
          end
        end
        PRE: begin
          fill_cnt <= fill_cnt + AW'(1);
          if ((p_lat == '0) || (fill_cnt == (p_lat - AW'(1)))) state <= WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig_edge) begin
            rd_addr   <= wr_ptr - p_lat;
            rd_issued <= '0;
            total_len <= {1'b0, p_lat} + n_lat;
            post_cnt  <= LW'(1);
            triggered <= 1'b1;
            state     <= (n_lat == LW'(1)) ? READ : POST;
          end
        end
        POST: begin
          post_cnt <= post_cnt + LW'(1);
          if (post_cnt == (n_lat - LW'(1))) state <= READ;
        end
        READ: begin
          if (pop && m_tlast) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Two-entry skid buffer; entry 0 drives the stream outputs directly.
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      skid_cnt   <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tlast    <= 1'b0;
      skid_dat1  <= '0;
      skid_last1 <= 1'b0;
    end else begin
      skid_cnt <= skid_nxt;
      m_tvalid <= (skid_nxt != 2'd0);
      case ({inflight, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) begin
            m_tdata <= ram_q;
            m_tlast <= inflight_last;
          end else begin
            skid_dat1  <= ram_q;
            skid_last1 <= inflight_last;
          end
        end
        2'b01: begin
          m_tdata <= skid_dat1;
          m_tlast <= skid_last1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            m_tdata <= ram_q;
            m_tlast <= inflight_last;
          end else begin
            m_tdata    <= skid_dat1;
            m_tlast    <= skid_last1;
            skid_dat1  <= ram_q;
            skid_last1 <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// Randomized bench for trigger_capture with a record-level reference model
// built from the recorded input history.
module tb_trigger_capture;

  localparam int DW    = 14;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int HIST  = 32768;

  logic          adc_clk = 1'b0;
  logic          adc_rst;
  logic [DW-1:0] adc_dat_a;
  logic          trigger;
  logic          arm;
  logic [AW-1:0] pre_samples;
  logic [AW-1:0] post_samples;
  logic          busy;
  logic          triggered;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  int compared   = 0;
  int mismatched = 0;

  int hist_dat [HIST];
  bit hist_trig [HIST];
  int cyc     = 0;
  int arm_idx = 0;

  int got_q [$];
  bit last_q [$];
  int exp_q [$];
  int trig_pulses = 0;
  bit seen_last   = 1'b0;

  bit            stall_pend = 1'b0;
  logic [DW-1:0] stall_dat;
  logic          stall_last;

  bit ramp_mode  = 1'b0;
  int ramp_val   = 0;
  bit rand_ready = 1'b0;

  trigger_capture #(.DW(DW), .AW(AW)) dut (
    .adc_clk      (adc_clk),
    .adc_rst      (adc_rst),
    .adc_dat_a    (adc_dat_a),
    .trigger      (trigger),
    .arm          (arm),
    .pre_samples  (pre_samples),
    .post_samples (post_samples),
    .busy         (busy),
    .triggered    (triggered),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Record what the DUT samples on each rising edge.
  always @(posedge adc_clk) begin
    if (cyc < HIST) begin
      hist_dat[cyc]  = int'(adc_dat_a);
      hist_trig[cyc] = trigger;
    end
    if (arm && !adc_rst) arm_idx = cyc;
    cyc = cyc + 1;
  end

  // Observe the stream away from the clock edge: transfers, stall stability, trigger pulses.
  always @(negedge adc_clk) begin
    if (adc_rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check_output("stall_valid", 32'(m_tvalid), 32'd1);
        check_output("stall_data", 32'(m_tdata), 32'(stall_dat));
        check_output("stall_last", 32'(m_tlast), 32'(stall_last));
      end
      if (triggered) trig_pulses++;
      if (m_tvalid && m_tready) begin
        got_q.push_back(int'(m_tdata));
        last_q.push_back(m_tlast);
        if (m_tlast) seen_last = 1'b1;
      end
      stall_pend = m_tvalid && !m_tready;
      stall_dat  = m_tdata;
      stall_last = m_tlast;
    end
  end

  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge adc_clk);
      #1;
      arm       = 1'b0;
      adc_dat_a = ramp_mode ? DW'(ramp_val) : DW'($urandom);
      ramp_val++;
      m_tready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic do_arm(input int p, input int post);
    got_q.delete();
    last_q.delete();
    trig_pulses  = 0;
    seen_last    = 1'b0;
    pre_samples  = AW'(p);
    post_samples = AW'(post);
    arm          = 1'b1;
    apply_stimulus(1);
  endtask

  task automatic wait_record(input int budget);
    int n;
    n = 0;
    while (!seen_last && n < budget) begin
      apply_stimulus(1);
      n++;
    end
    check_output("record_done", 32'(seen_last), 32'd1);
    apply_stimulus(2);
    check_output("busy_after", 32'(busy), 32'd0);
  endtask

  // Reference: the record is the P samples before the first rising edge seen after
  // the pre-trigger window has filled, plus N samples starting at that edge.
  task automatic build_expected(input int p, input int post);
    int n;
    int s;
    bit found;
    n = (post == 0) ? 1 : post;
    if (n > DEPTH - p) n = DEPTH - p;
    exp_q.delete();
    found = 1'b0;
    s = 0;
    for (int i = arm_idx + ((p > 0) ? p : 1); i < cyc && i < HIST; i++) begin
      if (!found && hist_trig[i] && !hist_trig[i-1]) begin
        found = 1'b1;
        s = i;
      end
    end
    check_output("edge_found", 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < p + n; k++) exp_q.push_back(hist_dat[s - p + k]);
    end
  endtask

  task automatic verify_record(input int p, input int post);
    build_expected(p, post);
    check_output("rec_len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_output($sformatf("data[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
      check_output($sformatf("last[%0d]", i), 32'(last_q[i]), 32'(i == exp_q.size() - 1));
    end
    check_output("trig_pulses", 32'(trig_pulses), 32'd1);
  endtask

  initial begin
    int p;
    int post;
    int e;
    int n;
    adc_rst      = 1'b1;
    trigger      = 1'b0;
    arm          = 1'b0;
    m_tready     = 1'b1;
    adc_dat_a    = '0;
    pre_samples  = '0;
    post_samples = '0;
    apply_stimulus(4);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_triggered", 32'(triggered), 32'd0);
    check_output("rst_tvalid", 32'(m_tvalid), 32'd0);
    check_output("rst_tlast", 32'(m_tlast), 32'd0);
    check_output("rst_tdata", 32'(m_tdata), 32'd0);
    adc_rst = 1'b0;

    // Ramp, P=4 N=8, edge on value 100.
    ramp_mode = 1'b1;
    ramp_val  = 50;
    apply_stimulus(1);
    do_arm(4, 8);
    n = 0;
    while (adc_dat_a != DW'(100) && n < 500) begin
      apply_stimulus(1);
      n++;
    end
    trigger = 1'b1;
    wait_record(200);
    trigger = 1'b0;
    verify_record(4, 8);
    check_output("ramp_len", 32'(got_q.size()), 32'd12);
    check_output("ramp_first", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'd96);
    check_output("ramp_last", (got_q.size() > 0) ? 32'(got_q[got_q.size()-1]) : 32'hFFFF_FFFF, 32'd107);

    // Edge inside the pre-trigger window must be ignored.
    apply_stimulus(3);
    do_arm(16, 8);
    apply_stimulus(5);
    trigger = 1'b1;
    apply_stimulus(2);
    trigger = 1'b0;
    apply_stimulus(30);
    trigger = 1'b1;
    e = int'(adc_dat_a);
    wait_record(200);
    trigger = 1'b0;
    verify_record(16, 8);
    check_output("second_edge", (got_q.size() > 16) ? 32'(got_q[16]) : 32'hFFFF_FFFF, 32'(e));

    // Buffer wrap: edge written at address 1020.
    adc_rst = 1'b1;
    apply_stimulus(2);
    adc_rst = 1'b0;
    apply_stimulus(1);
    do_arm(8, 8);
    n = 0;
    while (cyc < arm_idx + 1020 && n < 2000) begin
      apply_stimulus(1);
      n++;
    end
    trigger = 1'b1;
    wait_record(200);
    trigger = 1'b0;
    verify_record(8, 8);
    for (int i = 1; i < got_q.size(); i++)
      check_output("wrap_contig", 32'(got_q[i]), 32'((got_q[0] + i) % (1 << DW)));

    // Random data, random back-pressure, random P/N and trigger history.
    ramp_mode  = 1'b0;
    rand_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      p    = $urandom_range(0, 60);
      post = $urandom_range(0, 80);
      trigger = 1'($urandom_range(0, 1));
      apply_stimulus(2);
      do_arm(p, post);
      apply_stimulus(p + $urandom_range(2, 20));
      trigger = 1'b0;
      apply_stimulus($urandom_range(1, 5));
      trigger = 1'b1;
      wait_record(4 * (p + post + 1) + 200);
      trigger = 1'b0;
      verify_record(p, post);
    end

    // Minimum record: P=0, post_samples=0 gives a single sample.
    rand_ready = 1'b0;
    apply_stimulus(2);
    do_arm(0, 0);
    apply_stimulus(4);
    trigger = 1'b1;
    wait_record(100);
    trigger = 1'b0;
    verify_record(0, 0);
    check_output("min_len", 32'(got_q.size()), 32'd1);

    // Clamp: P=1000, N=100 becomes a full-depth record.
    rand_ready = 1'b1;
    apply_stimulus(2);
    do_arm(1000, 100);
    apply_stimulus(1010);
    trigger = 1'b1;
    wait_record(6000);
    trigger = 1'b0;
    verify_record(1000, 100);
    check_output("clamp_len", 32'(got_q.size()), 32'd1024);

    // Reset during POST.
    rand_ready = 1'b0;
    apply_stimulus(2);
    do_arm(4, 50);
    apply_stimulus(8);
    trigger = 1'b1;
    apply_stimulus(10);
    adc_rst = 1'b1;
    apply_stimulus(1);
    check_output("rpost_busy", 32'(busy), 32'd0);
    check_output("rpost_tvalid", 32'(m_tvalid), 32'd0);
    check_output("rpost_triggered", 32'(triggered), 32'd0);
    adc_rst = 1'b0;
    trigger = 1'b0;
    apply_stimulus(3);

    // Reset during READ, with arm held in the reset cycle.
    do_arm(4, 20);
    apply_stimulus(8);
    trigger = 1'b1;
    n = 0;
    while (got_q.size() < 3 && n < 200) begin
      apply_stimulus(1);
      n++;
    end
    check_output("rread_started", 32'(got_q.size() >= 3), 32'd1);
    adc_rst = 1'b1;
    arm     = 1'b1;
    apply_stimulus(1);
    check_output("rread_busy", 32'(busy), 32'd0);
    check_output("rread_tvalid", 32'(m_tvalid), 32'd0);
    check_output("rread_tlast", 32'(m_tlast), 32'd0);
    check_output("rread_tdata", 32'(m_tdata), 32'd0);
    adc_rst = 1'b0;
    trigger = 1'b0;
    apply_stimulus(1);
    check_output("arm_in_rst", 32'(busy), 32'd0);
    apply_stimulus(2);

    // Fresh capture after the aborted ones.
    rand_ready = 1'b1;
    do_arm(10, 15);
    apply_stimulus(20);
    trigger = 1'b1;
    wait_record(300);
    trigger = 1'b0;
    verify_record(10, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 SHALL have parameter DW, default 14, ADC sample width.
REQ-002 SHALL have parameter AW, default 10, buffer address width (depth 2^AW = 1024 samples).
REQ-003 SHALL have port adc_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port adc_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port adc_dat_a, input, DW, ADC sample, one per cycle.
REQ-006 SHALL have port trigger, input, 1, level output of the threshold comparator.
REQ-007 SHALL have port arm, input, 1, single-cycle pulse that starts an acquisition.
REQ-008 SHALL have port pre_samples, input, AW, samples kept before the trigger edge.
REQ-009 SHALL have port post_samples, input, AW, samples kept from the trigger edge on (0 means 1).
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port triggered, output, 1, single-cycle pulse on the accepted trigger edge.
REQ-012 SHALL have port m_tdata, output, DW, readout sample.
REQ-013 SHALL have port m_tvalid, output, 1, readout data valid.
REQ-014 SHALL have port m_tready, input, 1, downstream accept.
REQ-015 SHALL have port m_tlast, output, 1, marks final sample of a record.

Function
REQ-016 SHALL implement states IDLE, PRE, WAIT_TRIG, POST, READ.
REQ-017 SHALL register adc_dat_a and trigger once on input; all timing below refers to registered values.
REQ-018 SHALL, on arm in IDLE, latch pre_samples (P) and post_samples (N, clamped to 1..2^AW-P), clear the fill counter and enter PRE; arm outside IDLE SHALL be ignored.
REQ-019 SHALL in PRE, WAIT_TRIG and POST write one sample per cycle to a circular buffer at wr_ptr, wr_ptr incrementing modulo 2^AW.
REQ-020 SHALL leave PRE for WAIT_TRIG once P samples are written (immediately if P=0).
REQ-021 SHALL detect a trigger as a registered 0->1 transition; edges during PRE SHALL be ignored; a trigger held high on entry to WAIT_TRIG SHALL NOT count.
REQ-022 SHALL on the accepted edge store start = wr_ptr - P (mod 2^AW), pulse triggered for one cycle, and enter POST with the edge sample as post sample 0.
REQ-023 SHALL leave POST for READ after exactly N samples are written, including the edge sample.
REQ-024 SHALL in READ stream P+N samples from address start upward with wrap-around, AXI-Stream rules: m_tdata/m_tvalid stable while m_tvalid=1 and m_tready=0; a transfer occurs when both are high.
REQ-025 SHALL assert m_tlast with the (P+N)th sample and return to IDLE on its transfer.
REQ-026 SHALL sustain one transfer per cycle with m_tready held high, absorbing the 1-cycle RAM read latency with a 2-entry skid buffer.
REQ-027 SHALL present m_tvalid no later than 3 cycles after entering READ.

Reset
REQ-028 SHALL on adc_rst force state IDLE, busy=0, triggered=0, m_tvalid=0, m_tlast=0, m_tdata=0, wr_ptr=0, counters=0, skid buffer empty.
REQ-029 SHALL abort any acquisition or readout when adc_rst is asserted mid-operation; buffer contents SHALL NOT be cleared and are undefined afterwards.
REQ-030 SHALL ignore arm in the cycle adc_rst is high.

Structure
REQ-031 SHALL take the state enumeration and DW/AW defaults from shared package trig_pkg.
REQ-032 SHALL contain one sub-module, capture_ram: simple dual-port RAM, 2^AW x DW, one write port, registered read, no reset on contents.

Verification
REQ-033 SHALL cover: ramp input, P=4, N=8, trigger edge at ramp value 100 -> 12 samples 96..107, m_tlast on 107, triggered pulse once.
REQ-034 SHALL cover: trigger edge during PRE (P=16) then second edge in WAIT_TRIG -> capture aligned to second edge only.
REQ-035 SHALL cover: wr_ptr near 1020 at trigger, P=8, N=8 -> addresses wrap 1012..1023,0..3, data contiguous.
REQ-036 SHALL cover: m_tready random 50% -> stream identical to m_tready=1 case, no drop or duplicate, data stable under stall.
REQ-037 SHALL cover: P=1000, N=100 -> N clamped to 24, record length 1024.
REQ-038 SHALL cover: adc_rst in POST then in READ -> next cycle IDLE, m_tvalid=0, new arm captures correctly.
